// File: rtl/tty_text_writer_if.sv
// tty_text_writer_if
//   Bundles the byte-stream handshake and the character-RAM write bus of the
//   TTY text writer.
//   Signals:
//     in_valid, in_data[7:0] : byte source -> writer
//     in_ready               : writer -> byte source
//     ram_address[ADDR_W-1:0], ram_write, ram_writedata[7:0] : writer -> RAM
//   Modports:
//     master : byte source / RAM side (drives the stream, observes the RAM bus)
//     slave  : the writer itself
interface tty_text_writer_if #(
  parameter int ADDR_W = 16
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic [ADDR_W-1:0] ram_address;
  logic              ram_write;
  logic [7:0]        ram_writedata;

  modport master (
    output in_valid, in_data,
    input  in_ready,
    input  ram_address, ram_write, ram_writedata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready,
    output ram_address, ram_write, ram_writedata
  );
endinterface

// File: rtl/tty_text_writer.sv
// tty_text_writer
//   Interprets a byte stream as terminal output (printable glyphs, CR, LF, BS,
//   FF) and writes glyph codes into the character RAM, one write per clock.
//   The screen scrolls by moving top_row once every physical row has been used.
//   Ports:
//     clk, rst_n       : clock, asynchronous active-low reset
//     bus (slave)      : in_valid/in_data/in_ready byte stream,
//                        ram_address/ram_write/ram_writedata RAM write bus
//     cur_col, cur_row : cursor position (physical row)
//     top_row          : physical row shown at the top of the screen
//     busy             : high whenever not idle
module tty_text_writer #(
  parameter int COLS   = 40,
  parameter int ROWS   = 15,
  parameter int ADDR_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  tty_text_writer_if.slave   bus,
  output logic [7:0]         cur_col,
  output logic [7:0]         cur_row,
  output logic [7:0]         top_row,
  output logic               busy
);

  localparam logic [7:0]      SPACE    = 8'h20;
  localparam logic [ADDR_W:0] TOTAL_C  = (ADDR_W+1)'(ROWS * COLS);
  localparam logic [ADDR_W:0] COLS_C   = (ADDR_W+1)'(COLS);
  localparam logic [7:0]      LAST_COL = 8'(COLS - 1);
  localparam logic [7:0]      LAST_ROW = 8'(ROWS - 1);

  typedef enum logic [1:0] {
    S_CLEAR_ALL,
    S_IDLE,
    S_EXEC,
    S_CLEAR_ROW
  } state_t;

  state_t            state_reg, state_next;
  // One bit wider than the address so it can reach ROWS*COLS itself.
  logic [ADDR_W:0]   cnt_reg, cnt_next;
  logic [7:0]        col_reg, col_next;
  logic [7:0]        row_reg, row_next;
  logic [7:0]        top_reg, top_next;
  logic              full_reg, full_next;
  logic [7:0]        byte_reg, byte_next;
  logic              wr_reg, wr_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [7:0]        data_reg, data_next;

  logic [ADDR_W-1:0] row_base;
  logic [7:0]        adv_row, adv_top;
  logic              adv_full;
  logic              do_adv;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= 8'h20) && (b <= 8'h7E);
  endfunction

  assign row_base = ADDR_W'(row_reg) * ADDR_W'(COLS);

  // Line-advance results, precomputed from the current cursor.
  assign adv_row  = (row_reg == LAST_ROW) ? 8'd0 : row_reg + 8'd1;
  assign adv_full = full_reg | (row_reg == LAST_ROW);
  assign adv_top  = !adv_full ? top_reg :
                    (adv_row == LAST_ROW) ? 8'd0 : adv_row + 8'd1;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    col_next   = col_reg;
    row_next   = row_reg;
    top_next   = top_reg;
    full_next  = full_reg;
    byte_next  = byte_reg;
    wr_next    = 1'b0;
    addr_next  = addr_reg;
    data_next  = data_reg;
    do_adv     = 1'b0;

    case (state_reg)
      S_CLEAR_ALL: begin
        // The extra cycle at cnt==TOTAL lets the last write be seen before
        // in_ready rises.
        if (cnt_reg < TOTAL_C) begin
          wr_next   = 1'b1;
          addr_next = cnt_reg[ADDR_W-1:0];
          data_next = SPACE;
          cnt_next  = cnt_reg + 1'b1;
        end else begin
          state_next = S_IDLE;
        end
      end

      S_IDLE: begin
        if (bus.in_valid) begin
          byte_next  = bus.in_data;
          state_next = S_EXEC;
          // Glyph write is registered at the accepting edge so it is visible
          // during the EXEC cycle.
          if (is_printable(bus.in_data)) begin
            wr_next   = 1'b1;
            addr_next = row_base + ADDR_W'(col_reg);
            data_next = bus.in_data;
          end
        end
      end

      S_EXEC: begin
        state_next = S_IDLE;
        if (is_printable(byte_reg)) begin
          if (col_reg == LAST_COL) begin
            do_adv = 1'b1;
          end else begin
            col_next = col_reg + 8'd1;
          end
        end else begin
          case (byte_reg)
            8'h0D: col_next = 8'd0;
            8'h0A: do_adv = 1'b1;
            8'h08: if (col_reg != 8'd0) col_next = col_reg - 8'd1;
            8'h0C: begin
              col_next   = 8'd0;
              row_next   = 8'd0;
              top_next   = 8'd0;
              full_next  = 1'b0;
              cnt_next   = '0;
              state_next = S_CLEAR_ALL;
            end
            default: ;
          endcase
        end
        if (do_adv) begin
          col_next   = 8'd0;
          row_next   = adv_row;
          full_next  = adv_full;
          top_next   = adv_top;
          cnt_next   = '0;
          state_next = S_CLEAR_ROW;
        end
      end

      S_CLEAR_ROW: begin
        // row_reg already holds the new cursor row here.
        if (cnt_reg < COLS_C) begin
          wr_next   = 1'b1;
          addr_next = row_base + cnt_reg[ADDR_W-1:0];
          data_next = SPACE;
          cnt_next  = cnt_reg + 1'b1;
        end else begin
          state_next = S_IDLE;
        end
      end

      default: state_next = S_CLEAR_ALL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_CLEAR_ALL;
      cnt_reg   <= '0;
      col_reg   <= 8'd0;
      row_reg   <= 8'd0;
      top_reg   <= 8'd0;
      full_reg  <= 1'b0;
      byte_reg  <= 8'd0;
      wr_reg    <= 1'b0;
      addr_reg  <= '0;
      data_reg  <= SPACE;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      col_reg   <= col_next;
      row_reg   <= row_next;
      top_reg   <= top_next;
      full_reg  <= full_next;
      byte_reg  <= byte_next;
      wr_reg    <= wr_next;
      addr_reg  <= addr_next;
      data_reg  <= data_next;
    end
  end

  assign bus.in_ready      = (state_reg == S_IDLE);
  assign bus.ram_write     = wr_reg;
  assign bus.ram_address   = addr_reg;
  assign bus.ram_writedata = data_reg;
  assign busy              = (state_reg != S_IDLE);
  assign cur_col           = col_reg;
  assign cur_row           = row_reg;
  assign top_row           = top_reg;

endmodule
